// File: rtl/anim_frame_sequencer.sv
// rtl/anim_frame_sequencer.sv - animation id register and frame stepper
// Steps frame 0..lim-1 at PRESCALE>>speed cycles per frame; optional auto-advance of ids.
module anim_frame_sequencer #(
  parameter int PRESCALE_W = 24,
  parameter int PRESCALE   = 1_000_000,
  parameter int NUM_ANI    = 51,
  parameter int LOOPS      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       mode_auto,
  input  logic [5:0] anim_in,
  input  logic       pause,
  input  logic [2:0] speed,
  input  logic [4:0] limit,
  output logic [5:0] anim_sel,
  output logic [4:0] frame,
  output logic       frame_tick,
  output logic       loop_done,
  output logic       busy
);

  localparam int LC_W = $clog2(LOOPS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSE} state_t;

  state_t                  state;
  logic [PRESCALE_W-1:0]   presc;
  logic [LC_W-1:0]         loop_cnt;

  logic [PRESCALE_W-1:0]   base;
  logic [PRESCALE_W-1:0]   shifted;
  logic [PRESCALE_W-1:0]   period;
  logic                    terminal;
  logic [5:0]              lim;
  logic                    wrap;
  logic                    loop_last;
  logic                    manual_chg;
  logic [5:0]              next_sel;

  assign base       = PRESCALE_W'(PRESCALE);
  assign shifted    = base >> speed;
  assign period     = (shifted == '0) ? PRESCALE_W'(1) : shifted;
  // >= rather than == so a speed increase mid-count ticks at once instead of stalling
  assign terminal   = (presc >= period - PRESCALE_W'(1));
  assign lim        = (limit == 5'd0) ? 6'd32 : {1'b0, limit};
  assign wrap       = ({1'b0, frame} >= lim - 6'd1);
  assign loop_last  = (loop_cnt >= LC_W'(LOOPS - 1));
  assign manual_chg = !mode_auto && (anim_in != anim_sel);
  assign next_sel   = (anim_sel == 6'(NUM_ANI - 1)) ? 6'd0 : anim_sel + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      anim_sel   <= 6'd0;
      frame      <= 5'd0;
      frame_tick <= 1'b0;
      loop_done  <= 1'b0;
      busy       <= 1'b0;
      presc      <= '0;
      loop_cnt   <= '0;
    end else begin
      frame_tick <= 1'b0;
      loop_done  <= 1'b0;
      if (!ena) begin
        state <= IDLE;
        busy  <= 1'b0;
        frame <= 5'd0;
        presc <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= LOAD;
            busy  <= 1'b1;
            if (!mode_auto) begin
              anim_sel <= anim_in;
              if (anim_in != anim_sel) loop_cnt <= '0;
            end
          end
          LOAD: begin
            frame <= 5'd0;
            presc <= '0;
            state <= RUN;
          end
          RUN: begin
            if (pause) begin
              state <= PAUSE;
            end else if (manual_chg) begin
              state    <= LOAD;
              anim_sel <= anim_in;
              loop_cnt <= '0;
            end else if (terminal) begin
              presc      <= '0;
              frame_tick <= 1'b1;
              if (wrap) begin
                frame     <= 5'd0;
                loop_done <= 1'b1;
                if (mode_auto && loop_last) begin
                  state    <= LOAD;
                  loop_cnt <= '0;
                  anim_sel <= next_sel;
                end else begin
                  loop_cnt <= loop_cnt + LC_W'(1);
                end
              end else begin
                frame <= frame + 5'd1;
              end
            end else begin
              presc <= presc + PRESCALE_W'(1);
            end
          end
          PAUSE: begin
            if (!pause) state <= RUN;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
